// File: rtl/sb_pkg.sv
// Shared types and sizing helpers for the store buffer (store_buffer, sb_match).
package sb_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;
  localparam int PTR_W    = $clog2(SB_DEPTH);

  // One queued store: word address plus data, at the default widths.
  typedef struct packed {
    logic [SB_AW-1:2] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sb_match.sv
// Youngest-first priority select over the per-entry address match vector;
// returns whether any entry hit and the data of the youngest hitting entry.
module sb_match
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int DW    = SB_DW,
  parameter int PW    = ptr_width(DEPTH)
) (
  input  logic [DEPTH-1:0] match_i,
  input  logic [DW-1:0]    data_i [DEPTH],
  input  logic [PW-1:0]    tail_i,
  output logic             hit_o,
  output logic [DW-1:0]    fwd_data_o
);

  // Walk from oldest (tail-DEPTH) to youngest (tail-1); the last match written wins.
  always_comb begin
    hit_o      = 1'b0;
    fwd_data_o = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (match_i[tail_i - PW'(k)]) begin
        hit_o      = 1'b1;
        fwd_data_o = data_i[tail_i - PW'(k)];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the core M stage and a single-ported data memory.
// Define STORE_FWD_EN to forward load hits from the buffer instead of stalling them.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemWriteM,
  input  logic          MemReadM,
  input  logic [AW-1:0] ALUOutM,
  input  logic [DW-1:0] WriteDataM,
  output logic [DW-1:0] ReadDataM,
  output logic          StallM,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  input  logic          mem_ready,
  output logic          sb_empty
);

  localparam int          PW       = ptr_width(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [AW-1:2]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [PW:0]      count_q, count_d;
  logic [DEPTH-1:0] match;
  logic             full, load, hit, port_load, drain, enq, stall;

  assign full     = (count_q == FULL_CNT);
  assign sb_empty = (count_q == '0);
  assign load     = MemReadM & ~MemWriteM;

  // An entry is valid when its distance from head is below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    logic [PW-1:0] age;
    assign age       = PW'(gi) - head_q;
    assign match[gi] = ({1'b0, age} < count_q) && (addr_q[gi] == ALUOutM[AW-1:2]);
  end

`ifdef STORE_FWD_EN
  logic [DW-1:0] fwd_data;

  sb_match #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .PW    (PW)
  ) u_match (
    .match_i    (match),
    .data_i     (data_q),
    .tail_i     (tail_q),
    .hit_o      (hit),
    .fwd_data_o (fwd_data)
  );

  assign stall = MemWriteM & full & ~drain;
`else
  assign hit   = |match;
  assign stall = (MemWriteM & full & ~drain) | (load & hit);
`endif

  // A hitting load never uses the port: it is either forwarded or stalled.
  assign port_load = load & ~hit;
  assign drain     = ~sb_empty & mem_ready & ~port_load;
  assign enq       = MemWriteM & ~stall;

  assign StallM = stall;
  assign mem_we = drain;
  assign mem_a  = port_load ? ALUOutM : {addr_q[head_q], 2'b00};
  assign mem_wd = data_q[head_q];

  always_comb begin
    ReadDataM = mem_rd;
    if (!reset || MemWriteM) begin
      ReadDataM = '0;
    end
`ifdef STORE_FWD_EN
    else if (load && hit) begin
      ReadDataM = fwd_data;
    end
`endif
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq)   tail_d = tail_q + PW'(1);
    if (drain) head_d = head_q + PW'(1);
    if (enq && !drain)      count_d = count_q + (PW+1)'(1);
    else if (drain && !enq) count_d = count_q - (PW+1)'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= ALUOutM[AW-1:2];
      data_q[tail_q] <= WriteDataM;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer; expected memory writes are queued as
// stores are accepted and checked as the buffer drains them.
module tb_store_buffer;
  import sb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM, MemReadM;
  logic [31:0] ALUOutM, WriteDataM, ReadDataM;
  logic        StallM, mem_we, mem_ready, sb_empty;
  logic [31:0] mem_a, mem_wd, mem_rd;

  logic [31:0] tb_mem [256];
  sb_entry_t   exp_q [$];
  sb_entry_t   mon_e;
  int          vectors = 0;
  int          miscompares = 0;

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .MemReadM   (MemReadM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd),
    .mem_ready  (mem_ready),
    .sb_empty   (sb_empty)
  );

  always #5 clk = ~clk;

  always_comb mem_rd = tb_mem[mem_a[9:2]];

  always @(posedge clk) begin
    if (mem_we === 1'b1) tb_mem[mem_a[9:2]] <= mem_wd;
  end

  // Scoreboard: every memory write must be the oldest outstanding accepted store.
  always @(negedge clk) begin
    #2;
    if (reset === 1'b1 && mem_we === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL drain_unexpected: mem_a=%h mem_wd=%h, required no write", mem_a, mem_wd);
      end else begin
        mon_e = exp_q.pop_front();
        if (mem_a[31:2] !== mon_e.addr || mem_wd !== mon_e.data) begin
          miscompares++;
          $display("FAIL drain_order: mem_a=%h mem_wd=%h, required %h %h",
                   mem_a, mem_wd, {mon_e.addr, 2'b00}, mon_e.data);
        end
      end
    end
  end

  function automatic sb_entry_t mk(input logic [31:0] a, input logic [31:0] d);
    sb_entry_t e;
    e.addr = a[31:2];
    e.data = d;
    return e;
  endfunction

  task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    MemWriteM  = we;
    MemReadM   = re;
    ALUOutM    = a;
    WriteDataM = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_all(input string tag);
    bit done;
    done = 1'b0;
    mem_ready = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (sb_empty === 1'b1) done = 1'b1;
      else next_cycle();
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s_drain_timeout: sb_empty=%b, required 1 within 40 cycles", tag, sb_empty);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_lost_writes: %0d stores never written, required 0", tag, exp_q.size());
    end
    next_cycle();
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mem_ready = 1'b0;
    drive(1'b0, 1'b1, 32'h8, 32'h0);
    repeat (2) next_cycle();
    @(negedge clk);
    vectors++;
    if (sb_empty !== 1'b1 || mem_we !== 1'b0 || StallM !== 1'b0 || ReadDataM !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: sb_empty=%b mem_we=%b StallM=%b ReadDataM=%h, required 1 0 0 00000000",
               sb_empty, mem_we, StallM, ReadDataM);
    end
    next_cycle();
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    vectors++;
    if (sb_empty !== 1'b1 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: sb_empty=%b mem_we=%b, required 1 0", sb_empty, mem_we);
    end
    next_cycle();
  endtask

  task automatic test_fifo_drain();
    logic [31:0] a;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 32'h10 + 32'(4 * i);
      drive(1'b1, 1'b0, a, 32'(i + 1));
      @(negedge clk);
      vectors++;
      if (StallM !== 1'b0 || mem_we !== 1'b0) begin
        miscompares++;
        $display("FAIL fifo_enqueue: StallM=%b mem_we=%b, required 0 0", StallM, mem_we);
      end
      exp_q.push_back(mk(a, 32'(i + 1)));
      next_cycle();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    vectors++;
    if (sb_empty !== 1'b0 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL fifo_held: sb_empty=%b mem_we=%b, required 0 0", sb_empty, mem_we);
    end
    next_cycle();
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 32'h10 + 32'(4 * i);
      @(negedge clk);
      vectors++;
      if (mem_we !== 1'b1 || mem_a !== a) begin
        miscompares++;
        $display("FAIL fifo_drain: mem_we=%b mem_a=%h, required 1 %h", mem_we, mem_a, a);
      end
      next_cycle();
    end
    @(negedge clk);
    vectors++;
    if (sb_empty !== 1'b1 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL fifo_empty: sb_empty=%b mem_we=%b, required 1 0", sb_empty, mem_we);
    end
    next_cycle();
    mem_ready = 1'b0;
  endtask

  task automatic test_full_stall();
    logic [31:0] a;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 32'h30 + 32'(4 * i);
      drive(1'b1, 1'b0, a, 32'h11 + 32'(i));
      @(negedge clk);
      vectors++;
      if (StallM !== 1'b0) begin
        miscompares++;
        $display("FAIL full_fill: StallM=%b on store %0d, required 0", StallM, i);
      end
      exp_q.push_back(mk(a, 32'h11 + 32'(i)));
      next_cycle();
    end
    drive(1'b1, 1'b0, 32'h20, 32'h5);
    @(negedge clk);
    vectors++;
    if (StallM !== 1'b1 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL full_stall: StallM=%b mem_we=%b, required 1 0", StallM, mem_we);
    end
    next_cycle();
    mem_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (StallM !== 1'b0 || mem_we !== 1'b1 || mem_a !== 32'h30) begin
      miscompares++;
      $display("FAIL full_swap: StallM=%b mem_we=%b mem_a=%h, required 0 1 00000030", StallM, mem_we, mem_a);
    end
    exp_q.push_back(mk(32'h20, 32'h5));
    next_cycle();
    mem_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h24, 32'h6);
    @(negedge clk);
    vectors++;
    if (StallM !== 1'b1) begin
      miscompares++;
      $display("FAIL full_count_kept: StallM=%b, required 1 (still 4 entries)", StallM);
    end
    next_cycle();
    drain_all("full");
  endtask

  task automatic test_load_hit();
    mem_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h64, 32'hAA);
    exp_q.push_back(mk(32'h64, 32'hAA));
    next_cycle();
    drive(1'b1, 1'b0, 32'h64, 32'hBB);
    exp_q.push_back(mk(32'h64, 32'hBB));
    next_cycle();
    drive(1'b0, 1'b1, 32'h64, 32'h0);
`ifdef STORE_FWD_EN
    @(negedge clk);
    vectors++;
    if (ReadDataM !== 32'hBB || StallM !== 1'b0 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL hit_forward: ReadDataM=%h StallM=%b mem_we=%b, required 000000bb 0 0", ReadDataM, StallM, mem_we);
    end
    next_cycle();
    mem_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (ReadDataM !== 32'hBB || StallM !== 1'b0 || mem_we !== 1'b1 || mem_a !== 32'h64) begin
      miscompares++;
      $display("FAIL hit_forward_drain: ReadDataM=%h StallM=%b mem_we=%b mem_a=%h, required 000000bb 0 1 00000064",
               ReadDataM, StallM, mem_we, mem_a);
    end
    next_cycle();
`else
    @(negedge clk);
    vectors++;
    if (StallM !== 1'b1 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL hit_stall: StallM=%b mem_we=%b, required 1 0", StallM, mem_we);
    end
    next_cycle();
    mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (StallM !== 1'b1 || mem_we !== 1'b1) begin
        miscompares++;
        $display("FAIL hit_stall_drain: StallM=%b mem_we=%b at drain %0d, required 1 1", StallM, mem_we, i);
      end
      next_cycle();
    end
    @(negedge clk);
    vectors++;
    if (StallM !== 1'b0 || mem_we !== 1'b0 || mem_a !== 32'h64 || ReadDataM !== 32'hBB) begin
      miscompares++;
      $display("FAIL hit_release: StallM=%b mem_we=%b mem_a=%h ReadDataM=%h, required 0 0 00000064 000000bb",
               StallM, mem_we, mem_a, ReadDataM);
    end
    next_cycle();
`endif
    drain_all("hit");
  endtask

  task automatic test_load_miss();
    mem_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h40, 32'h7);
    exp_q.push_back(mk(32'h40, 32'h7));
    next_cycle();
    drive(1'b1, 1'b0, 32'h44, 32'h8);
    exp_q.push_back(mk(32'h44, 32'h8));
    next_cycle();
    mem_ready = 1'b1;
    drive(1'b0, 1'b1, 32'h80, 32'h0);
    @(negedge clk);
    vectors++;
    if (mem_a !== 32'h80 || mem_we !== 1'b0 || StallM !== 1'b0 || ReadDataM !== 32'hA000_0020) begin
      miscompares++;
      $display("FAIL miss_port: mem_a=%h mem_we=%b StallM=%b ReadDataM=%h, required 00000080 0 0 a0000020",
               mem_a, mem_we, StallM, ReadDataM);
    end
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    vectors++;
    if (mem_we !== 1'b1 || mem_a !== 32'h40) begin
      miscompares++;
      $display("FAIL miss_resume: mem_we=%b mem_a=%h, required 1 00000040", mem_we, mem_a);
    end
    next_cycle();
    drain_all("miss");
  endtask

  task automatic test_async_reset();
    mem_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h50, 32'h9);
    next_cycle();
    drive(1'b1, 1'b0, 32'h54, 32'hA);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    mem_ready = 1'b1;
    reset = 1'b0;
    #1;
    vectors++;
    if (sb_empty !== 1'b1 || mem_we !== 1'b0 || StallM !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: sb_empty=%b mem_we=%b StallM=%b, required 1 0 0", sb_empty, mem_we, StallM);
    end
    next_cycle();
    reset = 1'b1;
    mem_ready = 1'b0;
    drive(1'b0, 1'b1, 32'h50, 32'h0);
    @(negedge clk);
    vectors++;
    if (StallM !== 1'b0 || mem_a !== 32'h50 || ReadDataM !== 32'hA000_0014) begin
      miscompares++;
      $display("FAIL reset_discard: StallM=%b mem_a=%h ReadDataM=%h, required 0 00000050 a0000014",
               StallM, mem_a, ReadDataM);
    end
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_protocol_error();
    mem_ready = 1'b0;
    drive(1'b1, 1'b1, 32'h200, 32'h77);
    @(negedge clk);
    vectors++;
    if (ReadDataM !== 32'h0 || StallM !== 1'b0) begin
      miscompares++;
      $display("FAIL both_req: ReadDataM=%h StallM=%b, required 00000000 0", ReadDataM, StallM);
    end
    exp_q.push_back(mk(32'h200, 32'h77));
    next_cycle();
    drain_all("both");
    vectors++;
    if (tb_mem[8'h80] !== 32'h77) begin
      miscompares++;
      $display("FAIL both_written: mem[200]=%h, required 00000077", tb_mem[8'h80]);
    end
  endtask

  task automatic test_wrap();
    int sent;
    int occ;
    bit exp_drain, exp_stall;
    sent = 0;
    for (int cyc = 0; cyc < 100 && (sent < 10 || exp_q.size() != 0); cyc++) begin
      mem_ready = (cyc % 2 == 1);
      if (sent < 10) drive(1'b1, 1'b0, 32'h100 + 32'(4 * sent), 32'hC0DE_0000 + 32'(sent));
      else           drive(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      occ       = exp_q.size();
      exp_drain = (occ != 0) && mem_ready;
      exp_stall = (sent < 10) && (occ == 4) && !exp_drain;
      vectors++;
      if (StallM !== exp_stall || mem_we !== exp_drain || sb_empty !== (occ == 0)) begin
        miscompares++;
        $display("FAIL wrap_cycle%0d: StallM=%b mem_we=%b sb_empty=%b, required %b %b %b",
                 cyc, StallM, mem_we, sb_empty, exp_stall, exp_drain, (occ == 0));
      end
      if (sent < 10 && !exp_stall) begin
        exp_q.push_back(mk(32'h100 + 32'(4 * sent), 32'hC0DE_0000 + 32'(sent)));
        sent++;
      end
      next_cycle();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    mem_ready = 1'b0;
    vectors++;
    if (sent != 10 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL wrap_timeout: sent=%0d pending=%0d, required 10 0", sent, exp_q.size());
    end
    @(negedge clk);
    vectors++;
    if (sb_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_empty: sb_empty=%b, required 1", sb_empty);
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (tb_mem[8'(64 + i)] !== 32'hC0DE_0000 + 32'(i)) begin
        miscompares++;
        $display("FAIL wrap_mem%0d: mem=%h, required %h", i, tb_mem[8'(64 + i)], 32'hC0DE_0000 + 32'(i));
      end
    end
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = 32'hA000_0000 + 32'(i);
    reset = 1'b0;
    mem_ready = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_fifo_drain();
    test_full_stall();
    test_load_hit();
    test_load_miss();
    test_async_reset();
    test_protocol_error();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
